// File: rtl/neo_fix_pkg.sv
// rtl/neo_fix_pkg.sv - shared types, S-ROM address layout and column-offset table for the fix fetcher
//
// S-ROM byte address, MSB to LSB: {bank[1:0], code[11:0], col_off[1:0], row[2:0]}.
// Fetch byte k (0..3) reads column offset 2,3,0,1 and supplies pixels 2k (low
// nibble) and 2k+1 (high nibble).
package neo_fix_pkg;

    localparam int ROW_W   = 3;
    localparam int COL_W   = 2;
    localparam int CODE_W  = 12;
    localparam int BANK_W  = 2;
    localparam int PAL_W   = 4;
    localparam int SROM_AW = BANK_W + CODE_W + COL_W + ROW_W;

    // Column offset for fetch byte k lives at bits [2k+1:2k].
    localparam logic [7:0] COL_OFF_TBL = {2'd1, 2'd0, 2'd3, 2'd2};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FULL
    } fetch_state_e;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [CODE_W-1:0] code;
        logic [PAL_W-1:0]  pal;
        logic [ROW_W-1:0]  row;
    } tile_t;

    function automatic logic [COL_W-1:0] col_off(input logic [1:0] k);
        return COL_OFF_TBL[{k, 1'b0} +: 2];
    endfunction

    function automatic logic [SROM_AW-1:0] tile_addr(input tile_t t, input logic [1:0] k);
        return {t.bank, t.code, col_off(k), t.row};
    endfunction

endpackage

// File: rtl/neo_fix_fetch_if.sv
// rtl/neo_fix_fetch_if.sv - S-ROM req/ack byte port between the fix fetcher and the ROM arbiter
//
// SROM_REQ  : held high until SROM_ACK
// SROM_ADDR : byte address, stable while SROM_REQ is high
// SROM_ACK  : one-cycle acknowledge, SROM_DATA valid in the same cycle
// SROM_DATA : returned byte
interface neo_fix_fetch_if #(
    parameter int AW = 19
);
    logic          SROM_REQ;
    logic [AW-1:0] SROM_ADDR;
    logic          SROM_ACK;
    logic [7:0]    SROM_DATA;

    modport master (
        output SROM_REQ,
        output SROM_ADDR,
        input  SROM_ACK,
        input  SROM_DATA
    );

    modport slave (
        input  SROM_REQ,
        input  SROM_ADDR,
        output SROM_ACK,
        output SROM_DATA
    );
endinterface

// File: rtl/neo_fix_shifter.sv
// rtl/neo_fix_shifter.sv - fix-layer pixel shifter: row load, pixel select, palette and underrun count
//
// clk_i/rst_i   : clock, synchronous active-high reset
// ce_pix_i      : pixel enable; nothing advances without it
// tile_start_i  : with ce_pix_i, load a new row and emit pixel 0
// row_vld_i     : fetch buffer holds a complete row
// row_i/pal_i   : fetched row (pixel i at [4i+3:4i]) and its palette
// pix_color_o   : registered pixel colour (0 = transparent)
// pix_pal_o     : registered palette of the current pixel
// underrun_o    : saturating count of loads that found no complete row
module neo_fix_shifter #(
    parameter int UNDERRUN_CNT_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ce_pix_i,
    input  logic                      tile_start_i,
    input  logic                      row_vld_i,
    input  logic [31:0]               row_i,
    input  logic [3:0]                pal_i,
    output logic [3:0]                pix_color_o,
    output logic [3:0]                pix_pal_o,
    output logic [UNDERRUN_CNT_W-1:0] underrun_o
);

    // Pixel 0 goes straight to the output register on load, so only the
    // remaining seven pixels are kept; zeros shift in behind them so the
    // output falls to transparent after pixel 7.
    logic [27:0]               sh_q;
    logic [3:0]                color_q;
    logic [3:0]                pal_q;
    logic [UNDERRUN_CNT_W-1:0] urun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q    <= '0;
            color_q <= '0;
            pal_q   <= '0;
            urun_q  <= '0;
        end else if (ce_pix_i) begin
            if (tile_start_i) begin
                if (row_vld_i) begin
                    color_q <= row_i[3:0];
                    sh_q    <= row_i[31:4];
                    pal_q   <= pal_i;
                end else begin
                    color_q <= '0;
                    sh_q    <= '0;
                    pal_q   <= '0;
                    if (!(&urun_q)) begin
                        urun_q <= urun_q + UNDERRUN_CNT_W'(1);
                    end
                end
            end else begin
                color_q <= sh_q[3:0];
                sh_q    <= {4'b0, sh_q[27:4]};
            end
        end
    end

    assign pix_color_o = color_q;
    assign pix_pal_o   = pal_q;
    assign underrun_o  = urun_q;

endmodule

// File: rtl/neo_fix_fetch.sv
// rtl/neo_fix_fetch.sv - fix-layer row fetcher: latches tile entries, fetches 4 S-ROM bytes per row, feeds the shifter
//
// CLK/RESET     : clock, synchronous active-high reset
// CE_PIX        : pixel enable
// FIX_LOAD      : strobe, latch FIX_CODE/FIX_PAL/FIX_ROW and the effective bank
// BANK/CMC_EN   : CMC bank, used only when CMC_EN=1 (else bank 0)
// TILE_START    : with CE_PIX, pixel 0 of a new tile is due
// srom          : S-ROM req/ack byte port (master side)
// PIX_COLOR/PIX_PAL : registered pixel colour and palette
// UNDERRUN      : saturating underrun count
module neo_fix_fetch
    import neo_fix_pkg::*;
#(
    parameter int AW             = SROM_AW,
    parameter int UNDERRUN_CNT_W = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      CE_PIX,
    input  logic                      FIX_LOAD,
    input  logic [11:0]               FIX_CODE,
    input  logic [3:0]                FIX_PAL,
    input  logic [2:0]                FIX_ROW,
    input  logic [1:0]                BANK,
    input  logic                      CMC_EN,
    input  logic                      TILE_START,
    neo_fix_fetch_if.master           srom,
    output logic [3:0]                PIX_COLOR,
    output logic [3:0]                PIX_PAL,
    output logic [UNDERRUN_CNT_W-1:0] UNDERRUN
);

    fetch_state_e    state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    tile_t           cur_q, cur_d;
    tile_t           pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [3:0][7:0] fbuf_q, fbuf_d;

    tile_t new_t;
    tile_t nxt_t;
    logic  nxt_vld;
    logic  buf_vld;
    logic  xfer;

    // The fetch buffer is complete exactly while the FSM sits in FULL.
    assign buf_vld = (state_q == ST_FULL);
    assign xfer    = CE_PIX && TILE_START && buf_vld;

    always_comb begin
        new_t.bank = CMC_EN ? BANK : 2'd0;
        new_t.code = FIX_CODE;
        new_t.pal  = FIX_PAL;
        new_t.row  = FIX_ROW;
    end

    // A load in this very cycle is newer than anything already pending.
    assign nxt_t   = FIX_LOAD ? new_t : pend_q;
    assign nxt_vld = FIX_LOAD || pend_vld_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        req_d      = req_q;
        addr_d     = addr_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        fbuf_d     = fbuf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (FIX_LOAD) begin
                    cur_d   = new_t;
                    k_d     = 2'd0;
                    req_d   = 1'b1;
                    addr_d  = AW'(tile_addr(new_t, 2'd0));
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (FIX_LOAD) begin
                    pend_d     = new_t;
                    pend_vld_d = 1'b1;
                end
                if (!req_q) begin
                    // One-cycle gap after each ACK; cur_q already reflects a restart.
                    req_d  = 1'b1;
                    addr_d = AW'(tile_addr(cur_q, k_q));
                end else if (srom.SROM_ACK) begin
                    fbuf_d[k_q] = srom.SROM_DATA;
                    req_d       = 1'b0;
                    if (k_q == 2'd3) begin
                        // A complete row is kept even if a newer tile is pending;
                        // the pending entry is fetched after the shifter takes it.
                        state_d = ST_FULL;
                    end else if (nxt_vld) begin
                        cur_d      = nxt_t;
                        pend_vld_d = 1'b0;
                        k_d        = 2'd0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end

            ST_FULL: begin
                if (FIX_LOAD) begin
                    pend_d     = new_t;
                    pend_vld_d = 1'b1;
                end
                if (xfer) begin
                    if (nxt_vld) begin
                        cur_d      = nxt_t;
                        pend_vld_d = 1'b0;
                        k_d        = 2'd0;
                        req_d      = 1'b1;
                        addr_d     = AW'(tile_addr(nxt_t, 2'd0));
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            fbuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            fbuf_q     <= fbuf_d;
        end
    end

    assign srom.SROM_REQ  = req_q;
    assign srom.SROM_ADDR = addr_q;

    // cur_q is stable throughout FULL, so its palette belongs to the buffered row.
    neo_fix_shifter #(
        .UNDERRUN_CNT_W(UNDERRUN_CNT_W)
    ) u_shifter (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .ce_pix_i    (CE_PIX),
        .tile_start_i(TILE_START),
        .row_vld_i   (buf_vld),
        .row_i       (fbuf_q),
        .pal_i       (cur_q.pal),
        .pix_color_o (PIX_COLOR),
        .pix_pal_o   (PIX_PAL),
        .underrun_o  (UNDERRUN)
    );

endmodule

// File: tb/tb_neo_fix_fetch.sv
// tb/tb_neo_fix_fetch.sv - self-checking bench for neo_fix_fetch with address and pixel scoreboards
module tb_neo_fix_fetch;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CE_PIX = 1'b0;
    logic        FIX_LOAD = 1'b0;
    logic [11:0] FIX_CODE = '0;
    logic [3:0]  FIX_PAL = '0;
    logic [2:0]  FIX_ROW = '0;
    logic [1:0]  BANK = '0;
    logic        CMC_EN = 1'b0;
    logic        TILE_START = 1'b0;
    logic [3:0]  PIX_COLOR;
    logic [3:0]  PIX_PAL;
    logic [7:0]  UNDERRUN;

    neo_fix_fetch_if #(.AW(19)) srom ();

    neo_fix_fetch #(.AW(19), .UNDERRUN_CNT_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CE_PIX    (CE_PIX),
        .FIX_LOAD  (FIX_LOAD),
        .FIX_CODE  (FIX_CODE),
        .FIX_PAL   (FIX_PAL),
        .FIX_ROW   (FIX_ROW),
        .BANK      (BANK),
        .CMC_EN    (CMC_EN),
        .TILE_START(TILE_START),
        .srom      (srom),
        .PIX_COLOR (PIX_COLOR),
        .PIX_PAL   (PIX_PAL),
        .UNDERRUN  (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    logic [18:0] addr_sb[$];
    logic [3:0]  pix_sb[$];

    function automatic logic [18:0] exp_addr(input logic [1:0] b, input logic [11:0] c,
                                             input int k, input logic [2:0] r);
        logic [1:0] col;
        case (k)
            0:       col = 2'd2;
            1:       col = 2'd3;
            2:       col = 2'd0;
            default: col = 2'd1;
        endcase
        return {b, c, col, r};
    endfunction

    task automatic push_tile_addrs(input logic [1:0] b, input logic [11:0] c, input logic [2:0] r);
        for (int k = 0; k < 4; k++) addr_sb.push_back(exp_addr(b, c, k, r));
    endtask

    // row = {byte3, byte2, byte1, byte0}; pixel i is nibble i
    task automatic push_pixels(input logic [31:0] row);
        for (int i = 0; i < 8; i++) pix_sb.push_back(row[4*i +: 4]);
    endtask

    task automatic load_tile(input logic [11:0] c, input logic [3:0] p, input logic [2:0] r,
                             input logic [1:0] b, input logic en);
        @(negedge CLK);
        FIX_CODE = c; FIX_PAL = p; FIX_ROW = r; BANK = b; CMC_EN = en; FIX_LOAD = 1'b1;
        @(negedge CLK);
        FIX_LOAD = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int t;
        t = 0;
        while (srom.SROM_REQ !== 1'b1 && t < 64) begin
            @(negedge CLK);
            t++;
        end
        ok = (srom.SROM_REQ === 1'b1);
    endtask

    // Answer one request: check address against the scoreboard, ACK after dly cycles.
    task automatic serve(input logic [7:0] d, input int dly, input bit ts_at_ack);
        bit          ok;
        logic [18:0] e;
        wait_req(ok);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL req_timeout: SROM_REQ=%b required 1", srom.SROM_REQ);
            return;
        end
        n_assert++;
        if (addr_sb.size() == 0) begin
            n_fail++;
            $display("FAIL addr_unexpected: SROM_ADDR=%05h with no address expected", srom.SROM_ADDR);
            e = srom.SROM_ADDR;
        end else begin
            e = addr_sb.pop_front();
            if (srom.SROM_ADDR !== e) begin
                n_fail++;
                $display("FAIL srom_addr: got %05h required %05h", srom.SROM_ADDR, e);
            end
        end
        repeat (dly) @(negedge CLK);
        n_assert++;
        if (srom.SROM_REQ !== 1'b1 || srom.SROM_ADDR !== e) begin
            n_fail++;
            $display("FAIL req_hold: REQ=%b ADDR=%05h required REQ=1 ADDR=%05h",
                     srom.SROM_REQ, srom.SROM_ADDR, e);
        end
        srom.SROM_ACK = 1'b1;
        srom.SROM_DATA = d;
        if (ts_at_ack) begin
            CE_PIX = 1'b1;
            TILE_START = 1'b1;
        end
        @(negedge CLK);
        srom.SROM_ACK = 1'b0;
        srom.SROM_DATA = '0;
        CE_PIX = 1'b0;
        TILE_START = 1'b0;
        n_assert++;
        if (srom.SROM_REQ !== 1'b0) begin
            n_fail++;
            $display("FAIL req_drop_after_ack: SROM_REQ=%b required 0", srom.SROM_REQ);
        end
    endtask

    // TILE_START plus 8 pixel enables; then one more enable must give transparent.
    task automatic run_tile(input logic [3:0] pal);
        logic [3:0] e;
        @(negedge CLK);
        CE_PIX = 1'b1;
        TILE_START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            TILE_START = 1'b0;
            e = (pix_sb.size() > 0) ? pix_sb.pop_front() : 4'h0;
            n_assert++;
            if (PIX_COLOR !== e) begin
                n_fail++;
                $display("FAIL pix_color[%0d]: got %h required %h", i, PIX_COLOR, e);
            end
            n_assert++;
            if (PIX_PAL !== pal) begin
                n_fail++;
                $display("FAIL pix_pal[%0d]: got %h required %h", i, PIX_PAL, pal);
            end
        end
        @(negedge CLK);
        CE_PIX = 1'b0;
        n_assert++;
        if (PIX_COLOR !== 4'h0) begin
            n_fail++;
            $display("FAIL pix_after_row: got %h required 0", PIX_COLOR);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_assert++;
        if (srom.SROM_REQ !== 1'b0) begin
            n_fail++; $display("FAIL %s_req: got %b required 0", tag, srom.SROM_REQ);
        end
        n_assert++;
        if (srom.SROM_ADDR !== 19'h0) begin
            n_fail++; $display("FAIL %s_addr: got %05h required 00000", tag, srom.SROM_ADDR);
        end
        n_assert++;
        if (PIX_COLOR !== 4'h0) begin
            n_fail++; $display("FAIL %s_color: got %h required 0", tag, PIX_COLOR);
        end
        n_assert++;
        if (PIX_PAL !== 4'h0) begin
            n_fail++; $display("FAIL %s_pal: got %h required 0", tag, PIX_PAL);
        end
        n_assert++;
        if (UNDERRUN !== 8'h0) begin
            n_fail++; $display("FAIL %s_underrun: got %0d required 0", tag, UNDERRUN);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESET = 1'b0;
    endtask

    task automatic test_fetch_cmc();
        addr_sb.push_back(19'h48C75);
        addr_sb.push_back(19'h48C7D);
        addr_sb.push_back(19'h48C65);
        addr_sb.push_back(19'h48C6D);
        load_tile(12'h463, 4'hA, 3'd5, 2'd2, 1'b1);
        BANK = 2'd1;  // must not affect the fetch already latched
        serve(8'h21, 2, 1'b0);
        serve(8'h43, 2, 1'b0);
        serve(8'h65, 2, 1'b0);
        serve(8'h87, 2, 1'b0);
        push_pixels(32'h87654321);
        run_tile(4'hA);
    endtask

    task automatic test_cmc_off();
        addr_sb.push_back(19'h08C75);
        for (int k = 1; k < 4; k++) addr_sb.push_back(exp_addr(2'd0, 12'h463, k, 3'd5));
        load_tile(12'h463, 4'h3, 3'd5, 2'd3, 1'b0);
        serve(8'hF0, 1, 1'b0);
        serve(8'h1E, 1, 1'b0);
        serve(8'h2D, 1, 1'b0);
        serve(8'h3C, 1, 1'b0);
        push_pixels(32'h3C2D1EF0);
        run_tile(4'h3);
    endtask

    task automatic test_underrun();
        bit ok;
        push_tile_addrs(2'd1, 12'h123, 3'd2);
        load_tile(12'h123, 4'h5, 3'd2, 2'd1, 1'b1);
        serve(8'h10, 0, 1'b0);
        serve(8'h32, 0, 1'b0);
        serve(8'h54, 0, 1'b0);
        wait_req(ok);
        CE_PIX = 1'b1;
        TILE_START = 1'b1;
        @(negedge CLK);
        CE_PIX = 1'b0;
        TILE_START = 1'b0;
        n_assert++;
        if (PIX_COLOR !== 4'h0) begin
            n_fail++; $display("FAIL underrun_color: got %h required 0", PIX_COLOR);
        end
        n_assert++;
        if (UNDERRUN !== 8'd1) begin
            n_fail++; $display("FAIL underrun_count1: got %0d required 1", UNDERRUN);
        end
        serve(8'h76, 1, 1'b0);
        push_pixels(32'h76543210);
        run_tile(4'h5);
    endtask

    task automatic test_ack_with_tile_start();
        push_tile_addrs(2'd0, 12'hABC, 3'd7);
        load_tile(12'hABC, 4'h9, 3'd7, 2'd2, 1'b0);
        serve(8'h9A, 1, 1'b0);
        serve(8'hBC, 1, 1'b0);
        serve(8'hDE, 1, 1'b0);
        serve(8'hF1, 2, 1'b1);
        n_assert++;
        if (PIX_COLOR !== 4'h0) begin
            n_fail++; $display("FAIL simul_color: got %h required 0", PIX_COLOR);
        end
        n_assert++;
        if (UNDERRUN !== 8'd2) begin
            n_fail++; $display("FAIL simul_underrun: got %0d required 2", UNDERRUN);
        end
        push_pixels(32'hF1DEBC9A);
        run_tile(4'h9);
    endtask

    task automatic test_pending();
        bit ok;
        addr_sb.push_back(exp_addr(2'd0, 12'h123, 0, 3'd1));
        addr_sb.push_back(exp_addr(2'd0, 12'h123, 1, 3'd1));
        push_tile_addrs(2'd3, 12'h456, 3'd3);
        load_tile(12'h123, 4'h2, 3'd1, 2'd0, 1'b1);
        serve(8'h11, 1, 1'b0);
        wait_req(ok);
        // two loads during the byte-1 request: the last one wins
        FIX_CODE = 12'h789; FIX_PAL = 4'h1; FIX_ROW = 3'd6; BANK = 2'd1; CMC_EN = 1'b1;
        FIX_LOAD = 1'b1;
        @(negedge CLK);
        FIX_CODE = 12'h456; FIX_PAL = 4'h7; FIX_ROW = 3'd3; BANK = 2'd3;
        @(negedge CLK);
        FIX_LOAD = 1'b0;
        serve(8'h22, 1, 1'b0);
        serve(8'hA1, 1, 1'b0);
        serve(8'hB2, 1, 1'b0);
        serve(8'hC3, 1, 1'b0);
        serve(8'hD4, 1, 1'b0);
        push_pixels(32'hD4C3B2A1);
        run_tile(4'h7);
    endtask

    task automatic test_saturation();
        @(negedge CLK);
        CE_PIX = 1'b1;
        TILE_START = 1'b1;
        repeat (252) @(negedge CLK);
        n_assert++;
        if (UNDERRUN !== 8'd254) begin
            n_fail++; $display("FAIL underrun_254: got %0d required 254", UNDERRUN);
        end
        repeat (10) @(negedge CLK);
        CE_PIX = 1'b0;
        TILE_START = 1'b0;
        n_assert++;
        if (UNDERRUN !== 8'd255) begin
            n_fail++; $display("FAIL underrun_saturate: got %0d required 255", UNDERRUN);
        end
    endtask

    task automatic test_reset_midfetch();
        bit ok;
        load_tile(12'h321, 4'hC, 3'd4, 2'd1, 1'b1);
        wait_req(ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL midfetch_req: got %b required 1", srom.SROM_REQ);
        end
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midfetch");
        RESET = 1'b0;
        srom.SROM_ACK = 1'b1;
        srom.SROM_DATA = 8'h5A;
        @(negedge CLK);
        srom.SROM_ACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (srom.SROM_REQ !== 1'b0) begin
                n_fail++; $display("FAIL late_ack_req[%0d]: got %b required 0", i, srom.SROM_REQ);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        srom.SROM_ACK = 1'b0;
        srom.SROM_DATA = '0;
        test_reset();
        test_fetch_cmc();
        test_cmc_off();
        test_underrun();
        test_ack_with_tile_start();
        test_pending();
        test_saturation();
        test_reset_midfetch();
        n_assert++;
        if (addr_sb.size() != 0) begin
            n_fail++; $display("FAIL addr_leftover: %0d addresses never requested, required 0", addr_sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
